// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage and its neighbours.
package instr_fetch_unit_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] ALU_SUB    = 4'h1;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    IDLE = 3'd3,
    TRAP = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_pc_calc.sv
// Combinational next-PC selection and misalignment detection.
// IFU_MISALIGN_TRAP_EN: flag misaligned targets instead of forcing word alignment.
module instr_fetch_pc_calc
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch,
  input  logic        btaken,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] target;

  always_comb begin
    target = pc + PC_STEP;
    if (jalr) begin
      target = (rs1_data + imm) & ~32'h1;
    end else if (jal || (branch && btaken)) begin
      target = pc + imm;
    end
  end

`ifdef IFU_MISALIGN_TRAP_EN
  assign next_pc  = target;
  assign misalign = |target[1:0];
`else
  assign next_pc  = target & ~32'h3;
  assign misalign = 1'b0;
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch: PC register, imem req/gnt/rvalid handshake, instruction register.
// IFU_MISALIGN_TRAP_EN: misaligned next PC parks the unit in TRAP until reset.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_en,
  input  logic        branch,
  input  logic        btaken,
  input  logic        jal,
  input  logic        jalr,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        misalign_trap
);

  fetch_state_e state, state_nxt;
  logic [31:0]  next_pc;
  logic         misalign;
  logic         pc_take;
  logic         fetch_done;

  instr_fetch_pc_calc u_pc_calc (
    .pc       (pc),
    .branch   (branch),
    .btaken   (btaken),
    .jal      (jal),
    .jalr     (jalr),
    .imm      (imm),
    .rs1_data (rs1_data),
    .next_pc  (next_pc),
    .misalign (misalign)
  );

  // rvalid only counts in WAIT or in a REQ cycle that is also granted
  assign fetch_done = ((state == REQ) && imem_gnt && imem_rvalid) ||
                      ((state == WAIT) && imem_rvalid);
  assign pc_take    = (state == IDLE) && pc_en && !misalign;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      BOOT: state_nxt = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          state_nxt = imem_rvalid ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        instr_valid = 1'b1;
        if (pc_en) begin
          state_nxt = misalign ? TRAP : REQ;
        end
      end
      TRAP:    state_nxt = TRAP;
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= RESET_PC;
      instr <= INSTR_NOP;
    end else begin
      if (pc_take) begin
        pc <= next_pc;
      end
      if (fetch_done) begin
        instr <= imem_rdata;
      end
    end
  end

  assign imem_addr = pc;
  assign pc_plus4  = pc + PC_STEP;

`ifdef IFU_MISALIGN_TRAP_EN
  assign misalign_trap = (state == TRAP);
`else
  assign misalign_trap = 1'b0;
`endif

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Multi-cycle instruction fetch stage sitting directly upstream of the control unit and datapath. It owns the program counter, computes the next PC from branch/jump qualifiers, and fetches each instruction over a request/grant/valid instruction-memory handshake with variable latency. The fetched word is held in an instruction register that drives `instr` to the decoder. `instr_valid` tells the control unit when it may leave FETCH/DECODE.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; first fetch address.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `pc_en` in 1: commit next PC and start the next fetch; honoured only in IDLE.
- `branch` in 1: current instruction is a conditional branch.
- `btaken` in 1: branch comparison result from ALU; qualified by `branch`.
- `jal` in 1: jump (JAL/JALR family).
- `jalr` in 1: register-indirect jump; takes priority over `jal`/`branch`.
- `imm` in 32: sign-extended immediate.
- `rs1_data` in 32: rs1 operand for JALR.
- `imem_gnt` in 1: memory accepted the request this cycle.
- `imem_rvalid` in 1: `imem_rdata` valid this cycle.
- `imem_rdata` in 32: instruction word.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, always equal to `pc`.
- `pc` out 32: current PC.
- `pc_plus4` out 32: `pc + 4`, for link writeback.
- `instr` out 32: instruction register.
- `instr_valid` out 1: `instr` holds the word at `pc`.
- `misalign_trap` out 1: next-PC misalignment detected (see Configuration).

## Operation
- Next PC, all modulo 2^32:
  - If `jalr`: `(rs1_data + imm) & ~32'h1`.
  - Else if `jal` or (`branch` and `btaken`): `pc + imm`.
  - Else: `pc + 4`.
- FSM states: BOOT, REQ, WAIT, IDLE, TRAP.
- BOOT: entered on reset. Go to REQ next cycle.
- REQ: `imem_req`=1 with `imem_addr`=`pc`, both stable until grant.
  - `imem_gnt`=1 and `imem_rvalid`=1 in the same cycle: latch `imem_rdata` into `instr`, go to IDLE.
  - `imem_gnt`=1 only: go to WAIT.
  - Otherwise: stay in REQ.
- WAIT: `imem_req`=0. On `imem_rvalid`, latch `instr` and go to IDLE.
- IDLE: `instr_valid`=1. On `pc_en`, register the next PC into `pc` and go to REQ; `instr_valid` drops the following cycle.
- `pc_en` in BOOT, REQ, WAIT or TRAP is ignored; PC is unchanged.
- `imem_rvalid` outside WAIT, or outside a granted REQ cycle, is ignored.
- `imem_gnt` outside REQ is ignored.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4.
  - `instr`=32'h0000_0013 (NOP).
  - `instr_valid`=0, `imem_req`=0, `misalign_trap`=0.
  - State BOOT.
- `imem_req` rises the cycle after reset deasserts (BOOT→REQ).
- `pc_en` sampled in IDLE at cycle N:
  - New `pc` and `imem_req`=1 at N+1.
  - With a zero-wait memory (gnt and rvalid at N+1), `instr_valid`=1 and the new `instr` at N+2.
  - General latency: `instr_valid` rises 1 cycle after the `imem_rvalid` cycle.
- All outputs are registered or decoded from state; no combinational path from `imem_*` inputs to outputs.
- Reset asserted in REQ or WAIT aborts the fetch immediately. Any late `imem_rvalid` arriving in BOOT is dropped.
- PC wrap: `pc`=32'hFFFF_FFFC with sequential flow gives next PC 32'h0000_0000.

## Configuration
- Macro `IFU_MISALIGN_TRAP_EN`.
- Defined:
  - If the next PC has bits [1:0] != 0 when `pc_en` is taken, `pc` is not updated and the FSM goes to TRAP.
  - In TRAP: `imem_req`=0, `instr_valid`=0, `misalign_trap`=1. It stays there until reset.
- Undefined:
  - Next PC bits [1:0] are forced to 2'b00; TRAP is unreachable.
  - `misalign_trap` is tied to 0.
- The port exists in both builds.

## Structure
- Shared package (with the existing opcode/ALU defines):
  - Fetch state enum `fetch_state_e`.
  - `INSTR_NOP`=32'h0000_0013.
  - `PC_STEP`=4.
- One sub-module, `instr_fetch_pc_calc`: combinational next-PC and misalignment flag. The FSM, PC register and instruction register stay in the top module.

## Test plan
- Reset with `RESET_PC`=32'h100 and zero-wait memory: `imem_req` at first post-reset cycle with `imem_addr`=32'h100. Returned 32'h00500093 appears on `instr` with `instr_valid`=1 one cycle later.
- Grant delayed 3 cycles, rvalid 2 cycles after grant: `imem_req`/`imem_addr` held stable for 3 cycles, `instr_valid` low throughout, rises 1 cycle after rvalid.
- From `pc`=32'h200:
  - `branch`=1, `btaken`=1, `imm`=-8 → `pc`=32'h1F8.
  - `btaken`=0 → 32'h204.
  - `jalr` with `rs1_data`=32'h301, `imm`=4 → 32'h304.
- `pc_en` pulsed during WAIT: `pc` unchanged. Spurious `imem_rvalid` in IDLE: `instr` unchanged.
- Reset asserted in WAIT, then late rvalid arrives in BOOT: `instr`=NOP, `instr_valid`=0, new fetch at `RESET_PC`.
- With `IFU_MISALIGN_TRAP_EN` defined, `jal` with `imm`=2 from 32'h200: `misalign_trap`=1, `pc` stays 32'h200, no further `imem_req`. Without the macro, `pc`=32'h200 and the fetch proceeds.
